// File: rtl/core_pkg.sv
// Shared 8088 core definitions: flag-control command codes, ALU opcode groups,
// FLAGS bit positions and fixed-bit masks, and the interrupt-shadow states.
package core_pkg;

  localparam logic [3:0] CMD_NONE   = 4'd0;
  localparam logic [3:0] CMD_CLC    = 4'd1;
  localparam logic [3:0] CMD_STC    = 4'd2;
  localparam logic [3:0] CMD_CMC    = 4'd3;
  localparam logic [3:0] CMD_CLI    = 4'd4;
  localparam logic [3:0] CMD_STI    = 4'd5;
  localparam logic [3:0] CMD_CLD    = 4'd6;
  localparam logic [3:0] CMD_STD    = 4'd7;
  localparam logic [3:0] CMD_SAHF   = 4'd8;
  localparam logic [3:0] CMD_POPF   = 4'd9;
  localparam logic [3:0] CMD_INTACK = 4'd10;

  localparam logic [3:0] ALU_PASSA        = 4'b0000;
  localparam logic [3:0] ALU_NOTA         = 4'b0001;
  localparam logic [3:0] ALU_INCDEC_FIRST = 4'b0010;
  localparam logic [3:0] ALU_INCDEC_LAST  = 4'b0101;
  localparam logic [3:0] ALU_NOFLAGS7     = 4'b0111;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_TF = 8;
  localparam int FLAG_IF = 9;
  localparam int FLAG_DF = 10;
  localparam int FLAG_OF = 11;

  localparam logic [15:0] FLAGS_SET      = 16'hF002;
  localparam logic [15:0] FLAGS_CLR      = 16'h0028;
  localparam logic [15:0] FLAGS_WRITABLE = ~(FLAGS_SET | FLAGS_CLR);
  localparam logic [15:0] MASK_ARITH     = 16'h08D5;
  localparam logic [15:0] MASK_INCDEC    = 16'h08D4;
  localparam logic [15:0] MASK_SAHF      = 16'h00D5;

  localparam logic [1:0] SH_RUN    = 2'd0;
  localparam logic [1:0] SH_ARMED  = 2'd1;
  localparam logic [1:0] SH_SHADOW = 2'd2;

  // Which FLAGS bits an ALU op is allowed to write; inc/dec leave CF alone.
  function automatic logic [15:0] aluFlagMask(input logic [3:0] op);
    if (op == ALU_PASSA || op == ALU_NOTA || op == ALU_NOFLAGS7)
      return 16'h0000;
    else if (op >= ALU_INCDEC_FIRST && op <= ALU_INCDEC_LAST)
      return MASK_INCDEC;
    else
      return MASK_ARITH;
  endfunction

endpackage

// File: rtl/flags_cond.sv
// Jcc condition decoder: maps the 4-bit 8088 condition code onto the flags.
// Purely combinational so the LOOP/JCXZ sequencer can reuse it.
module flags_cond (
  input  logic [3:0] Cond,
  input  logic       cf,
  input  logic       pf,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       CondTrue
);

  logic baseTrue;

  // Even codes select a base test; odd codes are its complement.
  always_comb begin
    baseTrue = 1'b0;
    case (Cond[3:1])
      3'd0: baseTrue = of;
      3'd1: baseTrue = cf;
      3'd2: baseTrue = zf;
      3'd3: baseTrue = cf | zf;
      3'd4: baseTrue = sf;
      3'd5: baseTrue = pf;
      3'd6: baseTrue = sf ^ of;
      3'd7: baseTrue = zf | (sf ^ of);
      default: baseTrue = 1'b0;
    endcase
  end

  assign CondTrue = baseTrue ^ Cond[0];

endmodule

// File: rtl/flags_unit.sv
// Architectural FLAGS register: captures ALU flags one cycle after issue,
// executes flag-control commands, evaluates Jcc, and sequences TF and STI shadow.
module flags_unit
  import core_pkg::*;
(
  input  logic        CLKx4,
  input  logic        RESET,
  input  logic        AluIssue,
  input  logic [3:0]  AluOperation,
  input  logic        F_Overflow,
  input  logic        F_Neg,
  input  logic        F_Zero,
  input  logic        F_Aux,
  input  logic        F_Parity,
  input  logic        F_Carry,
  input  logic [3:0]  FlagCmd,
  input  logic [15:0] WrData,
  input  logic        InstrEnd,
  input  logic [3:0]  Cond,
  output logic [15:0] Flags,
  output logic        CondTrue,
  output logic        IntInhibit,
  output logic        IrqEnable,
  output logic        TrapReq
);

  logic [15:0] flagsReg;
  logic [15:0] flagsNext;
  logic [15:0] aluVec;
  logic [15:0] capMask;
  logic [15:0] cmdMask;
  logic [15:0] cmdVal;
  logic [3:0]  capOp;
  logic        capPend;
  logic        armCmd;
  logic [1:0]  shState;
  logic        tfAtStart;
  logic        trapReq;

  always_comb begin
    aluVec          = 16'h0000;
    aluVec[FLAG_OF] = F_Overflow;
    aluVec[FLAG_SF] = F_Neg;
    aluVec[FLAG_ZF] = F_Zero;
    aluVec[FLAG_AF] = F_Aux;
    aluVec[FLAG_PF] = F_Parity;
    aluVec[FLAG_CF] = F_Carry;
  end

  // Command overlay is applied on top of the ALU capture, so commands win per bit.
  always_comb begin
    cmdMask = 16'h0000;
    cmdVal  = 16'h0000;
    armCmd  = 1'b0;
    case (FlagCmd)
      CMD_NONE: ;
      CMD_CLC:  cmdMask[FLAG_CF] = 1'b1;
      CMD_STC:  begin cmdMask[FLAG_CF] = 1'b1; cmdVal[FLAG_CF] = 1'b1; end
      CMD_CMC:  begin cmdMask[FLAG_CF] = 1'b1; cmdVal[FLAG_CF] = ~flagsReg[FLAG_CF]; end
      CMD_CLI:  cmdMask[FLAG_IF] = 1'b1;
      CMD_STI:  begin cmdMask[FLAG_IF] = 1'b1; cmdVal[FLAG_IF] = 1'b1; armCmd = 1'b1; end
      CMD_CLD:  cmdMask[FLAG_DF] = 1'b1;
      CMD_STD:  begin cmdMask[FLAG_DF] = 1'b1; cmdVal[FLAG_DF] = 1'b1; end
      CMD_SAHF: begin cmdMask = MASK_SAHF; cmdVal = WrData; end
      CMD_POPF: begin
        cmdMask = FLAGS_WRITABLE;
        cmdVal  = WrData;
        armCmd  = ~flagsReg[FLAG_IF] & WrData[FLAG_IF];
      end
      CMD_INTACK: begin cmdMask[FLAG_IF] = 1'b1; cmdMask[FLAG_TF] = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    capMask   = capPend ? aluFlagMask(capOp) : 16'h0000;
    flagsNext = (flagsReg & ~capMask) | (aluVec & capMask);
    flagsNext = ((flagsNext & ~cmdMask) | (cmdVal & cmdMask)) & FLAGS_WRITABLE;
  end

  always_ff @(posedge CLKx4 or posedge RESET) begin
    if (RESET) begin
      flagsReg <= 16'h0000;
      capPend  <= 1'b0;
      capOp    <= 4'h0;
    end else begin
      flagsReg <= flagsNext;
      capPend  <= AluIssue;
      if (AluIssue)
        capOp <= AluOperation;
    end
  end

  // An arm command always wins over the InstrEnd that would otherwise advance.
  always_ff @(posedge CLKx4 or posedge RESET) begin
    if (RESET) begin
      shState <= SH_RUN;
    end else if (armCmd) begin
      shState <= SH_ARMED;
    end else if (InstrEnd) begin
      case (shState)
        SH_ARMED:  shState <= SH_SHADOW;
        SH_SHADOW: shState <= SH_RUN;
        default:   shState <= SH_RUN;
      endcase
    end
  end

  // tfAtStart holds TF as it was when the current instruction began.
  always_ff @(posedge CLKx4 or posedge RESET) begin
    if (RESET) begin
      tfAtStart <= 1'b0;
      trapReq   <= 1'b0;
    end else begin
      trapReq <= InstrEnd & tfAtStart & (FlagCmd != CMD_INTACK);
      if (FlagCmd == CMD_INTACK)
        tfAtStart <= 1'b0;
      else if (InstrEnd)
        tfAtStart <= flagsReg[FLAG_TF];
    end
  end

  assign Flags      = flagsReg | FLAGS_SET;
  assign IntInhibit = (shState != SH_RUN);
  assign IrqEnable  = flagsReg[FLAG_IF] & ~IntInhibit;
  assign TrapReq    = trapReq;

  flags_cond condDecode (
    .Cond     (Cond),
    .cf       (flagsReg[FLAG_CF]),
    .pf       (flagsReg[FLAG_PF]),
    .zf       (flagsReg[FLAG_ZF]),
    .sf       (flagsReg[FLAG_SF]),
    .of       (flagsReg[FLAG_OF]),
    .CondTrue (CondTrue)
  );

endmodule

// File: tb/tb_flags_unit.sv
// Directed self-checking bench for flags_unit: capture, collisions, conditions,
// interrupt shadow and single-step trap, each with hand-computed expectations.
module tb_flags_unit;

  logic        CLKx4;
  logic        RESET;
  logic        AluIssue;
  logic [3:0]  AluOperation;
  logic        F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity, F_Carry;
  logic [3:0]  FlagCmd;
  logic [15:0] WrData;
  logic        InstrEnd;
  logic [3:0]  Cond;
  logic [15:0] Flags;
  logic        CondTrue;
  logic        IntInhibit;
  logic        IrqEnable;
  logic        TrapReq;

  int total = 0;
  int bad   = 0;

  flags_unit dut (
    .CLKx4        (CLKx4),
    .RESET        (RESET),
    .AluIssue     (AluIssue),
    .AluOperation (AluOperation),
    .F_Overflow   (F_Overflow),
    .F_Neg        (F_Neg),
    .F_Zero       (F_Zero),
    .F_Aux        (F_Aux),
    .F_Parity     (F_Parity),
    .F_Carry      (F_Carry),
    .FlagCmd      (FlagCmd),
    .WrData       (WrData),
    .InstrEnd     (InstrEnd),
    .Cond         (Cond),
    .Flags        (Flags),
    .CondTrue     (CondTrue),
    .IntInhibit   (IntInhibit),
    .IrqEnable    (IrqEnable),
    .TrapReq      (TrapReq)
  );

  initial CLKx4 = 1'b0;
  always #5 CLKx4 = ~CLKx4;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; f is {OF,SF,ZF,AF,PF,CF} presented by the ALU this cycle.
  task automatic applyStimulus(input logic issue, input logic [3:0] op, input logic [5:0] f,
                               input logic [3:0] cmd, input logic [15:0] wr, input logic iend);
    AluIssue     = issue;
    AluOperation = op;
    {F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity, F_Carry} = f;
    FlagCmd      = cmd;
    WrData       = wr;
    InstrEnd     = iend;
    @(posedge CLKx4);
    #1;
    AluIssue = 1'b0;
    FlagCmd  = 4'd0;
    InstrEnd = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    AluIssue = 1'b0; AluOperation = 4'h0;
    {F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity, F_Carry} = 6'b0;
    FlagCmd = 4'd0; WrData = 16'h0000; InstrEnd = 1'b0; Cond = 4'h0;
    repeat (2) @(posedge CLKx4);
    #1;
    checkOutput("reset_flags", Flags, 16'hF002);
    checkOutput("reset_irqen", {15'b0, IrqEnable}, 16'h0);
    checkOutput("reset_trap", {15'b0, TrapReq}, 16'h0);
    checkOutput("reset_inhibit", {15'b0, IntInhibit}, 16'h0);
    Cond = 4'h0; #1;
    checkOutput("reset_cond_O", {15'b0, CondTrue}, 16'h0);
    Cond = 4'h1; #1;
    checkOutput("reset_cond_NO", {15'b0, CondTrue}, 16'h1);
    RESET = 1'b0;

    applyStimulus(1'b1, 4'b1101, 6'b000000, 4'd0, 16'h0, 1'b0);
    checkOutput("cap_not_yet", Flags, 16'hF002);
    applyStimulus(1'b0, 4'b0000, 6'b001001, 4'd0, 16'h0, 1'b0);
    checkOutput("cap_cf_zf", Flags, 16'hF043);

    applyStimulus(1'b1, 4'b0010, 6'b000000, 4'd0, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b0);
    checkOutput("incdec_keeps_cf", Flags, 16'hF003);

    applyStimulus(1'b1, 4'b1000, 6'b000000, 4'd0, 16'h0, 1'b0);
    applyStimulus(1'b1, 4'b0000, 6'b111111, 4'd0, 16'h0, 1'b0);
    checkOutput("b2b_first_all_set", Flags, 16'hF8D7);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b0);
    checkOutput("b2b_passa_no_update", Flags, 16'hF8D7);

    applyStimulus(1'b1, 4'b1111, 6'b000000, 4'd0, 16'h0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd2, 16'h0, 1'b0);
    checkOutput("collision_stc_wins", Flags, 16'hF003);

    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd8, 16'h00FF, 1'b0);
    checkOutput("sahf_low_flags", Flags, 16'hF0D7);

    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd9, 16'h0080, 1'b0);
    checkOutput("popf_sf_only", Flags, 16'hF082);
    checkOutput("popf_if0_no_arm", {15'b0, IntInhibit}, 16'h0);
    Cond = 4'hC; #1;
    checkOutput("cond_L", {15'b0, CondTrue}, 16'h1);
    Cond = 4'hD; #1;
    checkOutput("cond_GE", {15'b0, CondTrue}, 16'h0);
    Cond = 4'h8; #1;
    checkOutput("cond_S", {15'b0, CondTrue}, 16'h1);
    Cond = 4'h4; #1;
    checkOutput("cond_E", {15'b0, CondTrue}, 16'h0);
    Cond = 4'h7; #1;
    checkOutput("cond_A", {15'b0, CondTrue}, 16'h1);

    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd5, 16'h0, 1'b0);
    checkOutput("sti_if_set", Flags, 16'hF282);
    checkOutput("sti_armed_inhibit", {15'b0, IntInhibit}, 16'h1);
    checkOutput("sti_armed_irqen", {15'b0, IrqEnable}, 16'h0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b1);
    checkOutput("shadow_inhibit", {15'b0, IntInhibit}, 16'h1);
    checkOutput("shadow_irqen", {15'b0, IrqEnable}, 16'h0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd5, 16'h0, 1'b1);
    checkOutput("rearm_wins_inhibit", {15'b0, IntInhibit}, 16'h1);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b1);
    checkOutput("rearm_shadow_inhibit", {15'b0, IntInhibit}, 16'h1);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b1);
    checkOutput("run_inhibit", {15'b0, IntInhibit}, 16'h0);
    checkOutput("run_irqen", {15'b0, IrqEnable}, 16'h1);

    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd9, 16'h0380, 1'b0);
    checkOutput("popf_tf", Flags, 16'hF382);
    checkOutput("popf_if_kept_no_arm", {15'b0, IntInhibit}, 16'h0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b1);
    checkOutput("tf_setter_no_trap", {15'b0, TrapReq}, 16'h0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b0);
    checkOutput("idle_no_trap", {15'b0, TrapReq}, 16'h0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b1);
    checkOutput("trap_pulse", {15'b0, TrapReq}, 16'h1);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b0);
    checkOutput("trap_one_cycle", {15'b0, TrapReq}, 16'h0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd10, 16'h0, 1'b0);
    checkOutput("intack_flags", Flags, 16'hF082);
    checkOutput("intack_irqen", {15'b0, IrqEnable}, 16'h0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b1);
    checkOutput("intack_no_trap_a", {15'b0, TrapReq}, 16'h0);
    applyStimulus(1'b0, 4'b0000, 6'b000000, 4'd0, 16'h0, 1'b1);
    checkOutput("intack_no_trap_b", {15'b0, TrapReq}, 16'h0);

    applyStimulus(1'b1, 4'b1000, 6'b000000, 4'd0, 16'h0, 1'b0);
    {F_Overflow, F_Neg, F_Zero, F_Aux, F_Parity, F_Carry} = 6'b111111;
    #2;
    RESET = 1'b1;
    @(posedge CLKx4);
    #1;
    checkOutput("reset_mid_capture", Flags, 16'hF002);
    RESET = 1'b0;
    applyStimulus(1'b0, 4'b0000, 6'b111111, 4'd0, 16'h0, 1'b0);
    checkOutput("capture_abandoned", Flags, 16'hF002);
    checkOutput("reset_after_no_trap", {15'b0, TrapReq}, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
